// File: rtl/muxn_reg.sv
// muxn_reg: parametrised N:1 registered multiplexer with a one-entry valid/ready output stage.
// Optional MUXN_ERR_CNT_EN adds err_cnt, a saturating count of accepted out-of-range selects.
module muxn_reg #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SEL_W-1:0]        selector,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        sel_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
`ifdef MUXN_ERR_CNT_EN
  output logic [7:0]              err_cnt,
`endif
  input  logic                    err_clr
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic             state;
  logic             state_nxt;
  logic             accept;
  logic             sel_oor;
  logic [WIDTH-1:0] mux_data;

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign sel_oor   = (32'(selector) >= NUM_IN);

  // Channel 0 is the default, which also covers out-of-range selectors.
  always_comb begin
    mux_data = data_in[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      if (selector == SEL_W'(k)) begin
        mux_data = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      sel_out  <= '0;
    end else if (accept) begin
      data_out <= mux_data;
      sel_out  <= sel_oor ? '0 : selector;
    end
  end

  // Setting takes priority over err_clr so a coincident bad select is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

`ifdef MUXN_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (accept && sel_oor) begin
      if (err_clr) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != '1) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (err_clr) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule
